// File: rtl/piece_drop_ctrl_pkg.sv
// Shared types and constants for the falling-piece animation sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package drop_pkg;

    localparam int ROW_W = 3;
    localparam int COL_W = 3;
    localparam int CNT_W = 26;

    // Default tick reload values for a 50 MHz clock.
    localparam int unsigned TICK_SLOW_DEF = 32'd49999999;  // 1 s hold at the top row
    localparam int unsigned TICK_FAST_DEF = 32'd6249999;   // 1/8 s per row while falling

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FALL = 2'd2,
        ST_LAND = 2'd3
    } state_t;

endpackage

// File: rtl/piece_drop_ctrl_tick_counter.sv
// Loadable 26-bit down-counter; zero flags a phase tick and the count parks at 0.
// Latency: load takes effect on the next edge; zero is decoded from the register.
// Backpressure: none; load has priority over the decrement.
//
// Ports: clk, clear_b (sync active-low), load, load_val -> zero.
module tick_counter
    import drop_pkg::*;
(
    input  logic             clk,
    input  logic             clear_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piece_drop_ctrl.sv
// Connect-4 falling-piece sequencer: validate a drop, hold at the top, step down per tick, pulse land.
// Latency: reject/busy one edge after an accepted/refused start; hold = TICK_SLOW+1 cycles, each row = TICK_FAST+1.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, the caller watches busy.
//
// Ports: clk, clear_b (sync active-low); start/col/player from the game FSM; col_occ from board memory
//        (for cur_col while busy, for col while idle). Outputs busy, cur_row, cur_col, cur_player, land, reject
//        are all registered or decoded from the state register.
module piece_drop_ctrl
    import drop_pkg::*;
#(
    parameter int          ROWS      = 6,
    parameter int          COLS      = 7,
    parameter int unsigned TICK_SLOW = TICK_SLOW_DEF,
    parameter int unsigned TICK_FAST = TICK_FAST_DEF
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             start,
    input  logic [COL_W-1:0] col,
    input  logic             player,
    input  logic [ROWS-1:0]  col_occ,
    output logic             busy,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic             cur_player,
    output logic             land,
    output logic             reject
);

    localparam int               LAST_ROW_I = ROWS - 1;
    localparam logic [ROW_W:0]   LAST_ROW   = LAST_ROW_I[ROW_W:0];
    localparam logic [COL_W:0]   COLS_L     = COLS[COL_W:0];
    localparam logic [CNT_W-1:0] SLOW_L     = TICK_SLOW[CNT_W-1:0];
    localparam logic [CNT_W-1:0] FAST_L     = TICK_FAST[CNT_W-1:0];

    state_t             state_q,  state_d;
    logic [ROW_W-1:0]   row_q,    row_d;
    logic [COL_W-1:0]   col_q,    col_d;
    logic               player_q, player_d;
    logic               reject_q, reject_d;

    logic               tick;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;

    // One bit wider than the row so the bottom row does not wrap back to 0.
    logic [ROW_W:0]     next_row;
    logic               below_blocked;
    logic               col_bad;

    assign next_row = {1'b0, row_q} + (ROW_W + 1)'(1);
    // Short-circuit keeps the out-of-range col_occ index at the bottom row from mattering.
    assign below_blocked = (next_row > LAST_ROW) || col_occ[next_row[ROW_W-1:0]];
    assign col_bad       = ({1'b0, col} >= COLS_L);

    tick_counter u_tick (
        .clk      (clk),
        .clear_b  (clear_b),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (tick)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        player_d     = player_q;
        reject_d     = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = FAST_L;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (col_bad || col_occ[0]) begin
                        reject_d = 1'b1;
                    end else begin
                        col_d        = col;
                        player_d     = player;
                        row_d        = '0;
                        cnt_load     = 1'b1;
                        cnt_load_val = SLOW_L;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cnt_load = 1'b1;
                    state_d  = ST_FALL;
                end
            end
            ST_FALL: begin
                if (tick) begin
                    if (below_blocked) begin
                        // Counter is already parked at 0; no reload needed for LAND.
                        state_d = ST_LAND;
                    end else begin
                        row_d    = next_row[ROW_W-1:0];
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_LAND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear_b) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            player_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            player_q <= player_d;
            reject_q <= reject_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign land       = (state_q == ST_LAND);
    assign reject     = reject_q;
    assign cur_row    = row_q;
    assign cur_col    = col_q;
    assign cur_player = player_q;

endmodule
